anycore_store_queue: RTL and testbench

- Multi-entry store queue between the AnyCore data-cache store port and the AnyCore-to-L1.5 request decoder.
- Absorbs back-to-back stores from the core and issues them one at a time as single-cycle store-valid pulses.
- Holds each issued store stable until L1.5 acknowledges it, so no store is overwritten while in flight.
- Provides a load-vs-pending-store block hazard check so the core can hold a load that would bypass an older store.

---
 rtl/anycore_store_queue_if.sv | 28 ++
 rtl/anycore_store_queue.sv | 155 +++++++++++++++
 tb/tb_anycore_store_queue.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/anycore_store_queue_if.sv
// Store handshake bundle between the AnyCore store port, the store queue and the
// L1.5 request decoder. The queue uses the slave view; the environment uses the master view.
interface anycore_store_queue_if #(
    parameter int ST_ADDR_W = 40,
    parameter int DATA_W    = 64
);
    logic                 in_stvalid;
    logic [ST_ADDR_W-1:0] in_staddr;
    logic [DATA_W-1:0]    in_stdata;
    logic [2:0]           in_stsize;

    logic                 out_stvalid;
    logic [ST_ADDR_W-1:0] out_staddr;
    logic [DATA_W-1:0]    out_stdata;
    logic [2:0]           out_stsize;

    logic                 st_ack;

    modport slave (
        input  in_stvalid, in_staddr, in_stdata, in_stsize, st_ack,
        output out_stvalid, out_staddr, out_stdata, out_stsize
    );

    modport master (
        output in_stvalid, in_staddr, in_stdata, in_stsize, st_ack,
        input  out_stvalid, out_staddr, out_stdata, out_stsize
    );
endinterface

// File: rtl/anycore_store_queue.sv
// Circular store queue: absorbs core stores, issues them one at a time as single-cycle
// pulses, holds the head until acknowledged, and flags loads that hit a pending store block.
module anycore_store_queue #(
    parameter int DEPTH     = 4,
    parameter int ST_ADDR_W = 40,
    parameter int LD_ADDR_W = 36,
    parameter int DATA_W    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    anycore_store_queue_if.slave    sq_if,
    output logic                    sq_full,
    output logic                    sq_empty,
    output logic [$clog2(DEPTH):0]  sq_count,
    input  logic                    ld_chk_valid,
    input  logic [LD_ADDR_W-1:0]    ld_chk_addr,
    output logic                    ld_hazard,
    output logic                    err_overflow,
    output logic                    err_spurious_ack
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 out_stvalid_q, out_stvalid_d;
    logic [ST_ADDR_W-1:0] out_staddr_q, out_staddr_d;
    logic [DATA_W-1:0]    out_stdata_q, out_stdata_d;
    logic [2:0]           out_stsize_q, out_stsize_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 err_spurious_q, err_spurious_d;

    logic [ST_ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0]    mem_data_q [DEPTH];
    logic [2:0]           mem_size_q [DEPTH];

    logic                 push;
    logic                 pop;
    logic [DEPTH-1:0]     entry_vld;
    logic                 hit;

    // Status comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign sq_full  = (count_q == CNT_W'(DEPTH));
    assign sq_empty = (count_q == '0);
    assign sq_count = count_q;

    assign push = sq_if.in_stvalid && !sq_full;
    assign pop  = (state_q == ST_WAIT) && sq_if.st_ack;

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        out_stvalid_d  = 1'b0;
        out_staddr_d   = out_staddr_q;
        out_stdata_d   = out_stdata_q;
        out_stsize_d   = out_stsize_q;
        err_overflow_d = err_overflow_q | (sq_if.in_stvalid && sq_full);
        err_spurious_d = err_spurious_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (sq_if.st_ack) err_spurious_d = 1'b1;
                if (count_q != '0) begin
                    out_stvalid_d = 1'b1;
                    out_staddr_d  = mem_addr_q[rd_ptr_q];
                    out_stdata_d  = mem_data_q[rd_ptr_q];
                    out_stsize_d  = mem_size_q[rd_ptr_q];
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sq_if.st_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            out_stvalid_q  <= 1'b0;
            out_staddr_q   <= '0;
            out_stdata_q   <= '0;
            out_stsize_q   <= '0;
            err_overflow_q <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            out_stvalid_q  <= out_stvalid_d;
            out_staddr_q   <= out_staddr_d;
            out_stdata_q   <= out_stdata_d;
            out_stsize_q   <= out_stsize_d;
            err_overflow_q <= err_overflow_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= sq_if.in_staddr;
            mem_data_q[wr_ptr_q] <= sq_if.in_stdata;
            mem_size_q[wr_ptr_q] <= sq_if.in_stsize;
        end
    end

    always_comb begin
        entry_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) entry_vld[rd_ptr_q + PTR_W'(k)] = 1'b1;
        end
    end

    // The in-flight head stays in entry_vld until its ack edge, so a same-cycle pop still hazards.
    always_comb begin
        hit = push && (sq_if.in_staddr[ST_ADDR_W-1:4] == ld_chk_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (mem_addr_q[i][ST_ADDR_W-1:4] == ld_chk_addr)) hit = 1'b1;
        end
        ld_hazard = ld_chk_valid && hit;
    end

    assign sq_if.out_stvalid = out_stvalid_q;
    assign sq_if.out_staddr  = out_staddr_q;
    assign sq_if.out_stdata  = out_stdata_q;
    assign sq_if.out_stsize  = out_stsize_q;
    assign err_overflow      = err_overflow_q;
    assign err_spurious_ack  = err_spurious_q;
endmodule

// File: tb/tb_anycore_store_queue.sv
// Directed bench for anycore_store_queue: expected stores are queued when driven and
// compared against each out_stvalid pulse; timing, status, hazard and error flags checked inline.
module tb_anycore_store_queue;
    localparam int DEPTH     = 4;
    localparam int ST_ADDR_W = 40;
    localparam int LD_ADDR_W = 36;
    localparam int DATA_W    = 64;

    typedef struct {
        logic [ST_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]    data;
        logic [2:0]           size;
    } st_t;

    logic                   clk;
    logic                   rst_n;
    logic                   sq_full;
    logic                   sq_empty;
    logic [$clog2(DEPTH):0] sq_count;
    logic                   ld_chk_valid;
    logic [LD_ADDR_W-1:0]   ld_chk_addr;
    logic                   ld_hazard;
    logic                   err_overflow;
    logic                   err_spurious_ack;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    st_t exp_q[$];
    int  pulse_cyc[$];

    anycore_store_queue_if #(.ST_ADDR_W(ST_ADDR_W), .DATA_W(DATA_W)) sq_if ();

    anycore_store_queue #(
        .DEPTH(DEPTH), .ST_ADDR_W(ST_ADDR_W), .LD_ADDR_W(LD_ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sq_if            (sq_if),
        .sq_full          (sq_full),
        .sq_empty         (sq_empty),
        .sq_count         (sq_count),
        .ld_chk_valid     (ld_chk_valid),
        .ld_chk_addr      (ld_chk_addr),
        .ld_hazard        (ld_hazard),
        .err_overflow     (err_overflow),
        .err_spurious_ack (err_spurious_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest store still expected.
    always @(negedge clk) begin
        if (rst_n && sq_if.out_stvalid) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", 1, 0);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                check("pulse_addr", sq_if.out_staddr, e.addr);
                check("pulse_data", sq_if.out_stdata, e.data);
                check("pulse_size", sq_if.out_stsize, e.size);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) step();
    endtask

    task automatic drive_store(logic [ST_ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                               logic [2:0] s, bit accept);
        st_t e;
        sq_if.in_stvalid = 1'b1;
        sq_if.in_staddr  = a;
        sq_if.in_stdata  = d;
        sq_if.in_stsize  = s;
        if (accept) begin
            e.addr = a;
            e.data = d;
            e.size = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_pulse(int idx, output bit ok);
        int budget = 40;
        while (pulse_cyc.size() <= idx && budget > 0) begin
            step();
            budget--;
        end
        ok = (pulse_cyc.size() > idx);
        check("pulse_timeout", ok, 1);
    endtask

    // Acks each of n pulses dly cycles after it and checks the ack-to-next-pulse spacing.
    task automatic drain(int base, int n, int dly, string tag);
        int last_ack = -100;
        bit ok;
        for (int k = 0; k < n; k++) begin
            wait_pulse(base + k, ok);
            if (!ok) return;
            if (k > 0) check({tag, "_gap"}, (pulse_cyc[base+k] - last_ack) >= 2, 1);
            wait_to(pulse_cyc[base+k] + dly);
            sq_if.st_ack = 1'b1;
            last_ack = cyc;
            step();
            sq_if.st_ack = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  c0, base;
        bit  ok;
        logic [ST_ADDR_W-1:0] a;

        rst_n            = 1'b0;
        sq_if.in_stvalid = 1'b0;
        sq_if.in_staddr  = '0;
        sq_if.in_stdata  = '0;
        sq_if.in_stsize  = '0;
        sq_if.st_ack     = 1'b0;
        ld_chk_valid     = 1'b1;
        ld_chk_addr      = '0;

        // Reset state
        step();
        step();
        check("rst_empty", sq_empty, 1);
        check("rst_full", sq_full, 0);
        check("rst_count", sq_count, 0);
        check("rst_stvalid", sq_if.out_stvalid, 0);
        check("rst_staddr", sq_if.out_staddr, 0);
        check("rst_hazard", ld_hazard, 0);
        check("rst_err_ovf", err_overflow, 0);
        check("rst_err_spur", err_spurious_ack, 0);
        rst_n = 1'b1;
        ld_chk_valid = 1'b0;

        // Single store: pulse exactly two cycles after the push, empty the cycle after ack
        step();
        c0   = cyc;
        base = pulse_cyc.size();
        drive_store(40'h00_0000_1008, 64'h1122_3344_5566_7788, 3'd3, 1'b1);
        step();
        sq_if.in_stvalid = 1'b0;
        @(negedge clk);
        check("t1_count", sq_count, 1);
        check("t1_not_empty", sq_empty, 0);
        wait_to(c0 + 4);
        check("t1_one_pulse", pulse_cyc.size(), base + 1);
        if (pulse_cyc.size() > base) check("t1_pulse_cycle", pulse_cyc[base], c0 + 2);
        wait_to(c0 + 5);
        sq_if.st_ack = 1'b1;
        step();
        sq_if.st_ack = 1'b0;
        @(negedge clk);
        check("t1_empty_after_ack", sq_empty, 1);
        wait_to(c0 + 12);
        check("t1_no_repulse", pulse_cyc.size(), base + 1);
        check("t1_no_spur", err_spurious_ack, 0);

        // Burst of four fills the queue; a fifth is dropped
        c0   = cyc;
        base = pulse_cyc.size();
        for (int i = 0; i < 4; i++) begin
            drive_store(40'h00_0000_2000 + ST_ADDR_W'(i * 16), {$urandom, $urandom}, 3'(i), 1'b1);
            step();
        end
        sq_if.in_stvalid = 1'b0;
        @(negedge clk);
        check("t2_full", sq_full, 1);
        check("t2_count4", sq_count, 4);
        drive_store(40'h00_0000_2F00, 64'hDEAD_BEEF_0BAD_F00D, 3'd3, 1'b0);
        step();
        sq_if.in_stvalid = 1'b0;
        @(negedge clk);
        check("t2_overflow", err_overflow, 1);
        check("t2_count_still4", sq_count, 4);
        drain(base, 4, 3, "t2");
        check("t2_all_issued", exp_q.size(), 0);
        check("t2_empty", sq_empty, 1);

        // Full queue with same-cycle ack and push: push rejected, count 4 -> 3
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        check("t3_ovf_cleared", err_overflow, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive_store(40'h00_0000_3000 + ST_ADDR_W'(i * 16), {$urandom, $urandom}, 3'd2, 1'b1);
            step();
        end
        sq_if.in_stvalid = 1'b0;
        @(negedge clk);
        check("t3_full", sq_full, 1);
        drive_store(40'h00_0000_3F00, 64'h0123_4567_89AB_CDEF, 3'd1, 1'b0);
        sq_if.st_ack = 1'b1;
        step();
        sq_if.st_ack     = 1'b0;
        sq_if.in_stvalid = 1'b0;
        check("t3_count3", sq_count, 3);
        check("t3_overflow", err_overflow, 1);
        check("t3_not_full", sq_full, 0);
        base = pulse_cyc.size();
        drain(base, 3, 2, "t3");
        check("t3_all_issued", exp_q.size(), 0);

        // Hazard against pending entries and the store being pushed
        step();
        base = pulse_cyc.size();
        drive_store(40'h00_0000_1238, 64'hA5A5_5A5A_0F0F_F0F0, 3'd3, 1'b1);
        step();
        sq_if.in_stvalid = 1'b0;
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 36'h0_0000_0123;
        #1;
        check("t4_hazard_hit", ld_hazard, 1);
        ld_chk_addr = 36'h0_0000_0124;
        #1;
        check("t4_hazard_miss", ld_hazard, 0);
        ld_chk_valid = 1'b0;
        ld_chk_addr  = 36'h0_0000_0123;
        #1;
        check("t4_hazard_novalid", ld_hazard, 0);
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 36'h0_0000_00AB;
        drive_store(40'h00_0000_0AB0, 64'h1111_2222_3333_4444, 3'd2, 1'b1);
        #1;
        check("t4_hazard_bypass", ld_hazard, 1);
        step();
        sq_if.in_stvalid = 1'b0;
        drain(base, 2, 1, "t4");
        ld_chk_addr = 36'h0_0000_0123;
        #1;
        check("t4_hazard_after_pop", ld_hazard, 0);
        ld_chk_valid = 1'b0;

        // Wrap-around: ten stores, ack and next push in the same cycle
        step();
        base = pulse_cyc.size();
        for (int k = 0; k < 2; k++) begin
            drive_store(40'h00_0010_0000 + ST_ADDR_W'(k * 64), {$urandom, $urandom}, 3'(k), 1'b1);
            step();
        end
        sq_if.in_stvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_pulse(base + k, ok);
            if (!ok) break;
            wait_to(pulse_cyc[base+k] + 1);
            sq_if.st_ack = 1'b1;
            if (k + 2 < 10)
                drive_store(40'h00_0010_0000 + ST_ADDR_W'((k + 2) * 64), {$urandom, $urandom},
                            3'(k + 2), 1'b1);
            step();
            sq_if.st_ack     = 1'b0;
            sq_if.in_stvalid = 1'b0;
        end
        repeat (5) step();
        check("t5_pulse_total", pulse_cyc.size(), base + 10);
        check("t5_all_issued", exp_q.size(), 0);
        check("t5_empty", sq_empty, 1);

        // Asynchronous reset mid-WAIT, then spurious ack in IDLE
        step();
        base = pulse_cyc.size();
        a = 40'h00_0000_5670;
        drive_store(a, 64'hCAFE_F00D_1234_5678, 3'd3, 1'b1);
        step();
        sq_if.in_stvalid = 1'b0;
        wait_pulse(base, ok);
        ld_chk_valid = 1'b1;
        ld_chk_addr  = a[ST_ADDR_W-1:4];
        #1;
        check("t6_hazard_inflight", ld_hazard, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_stvalid", sq_if.out_stvalid, 0);
        check("t6_rst_staddr", sq_if.out_staddr, 0);
        check("t6_rst_stdata", sq_if.out_stdata, 0);
        check("t6_rst_stsize", sq_if.out_stsize, 0);
        check("t6_rst_empty", sq_empty, 1);
        check("t6_rst_count", sq_count, 0);
        check("t6_rst_hazard", ld_hazard, 0);
        check("t6_rst_err_ovf", err_overflow, 0);
        ld_chk_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_q.delete();
        base = pulse_cyc.size();
        repeat (8) step();
        check("t6_no_pulse_after_rst", pulse_cyc.size(), base);
        check("t6_no_spur_yet", err_spurious_ack, 0);
        sq_if.st_ack = 1'b1;
        step();
        sq_if.st_ack = 1'b0;
        check("t6_spurious_ack", err_spurious_ack, 1);
        repeat (3) step();
        check("t6_still_no_pulse", pulse_cyc.size(), base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
